font_rom_arbiter: RTL
=====================

# font_rom_arbiter

Shares the single 2 KB character-generator ROM (256 glyphs × 8 rows × 8 bits, address = {char[7:0], row[2:0]}) between the video scanout engine and the host/ESP font-readback port. Accepts at most one lookup per cycle, issues it to the pipelined ROM primitive (2-cycle read latency), and routes each returned byte, with optional inversion, to the requester that issued it. Video has priority, and a starvation counter guarantees the host forward progress. The block sits between the ROM wrapper instance and the two requesters in the video subsystem.

## Interface
- STARVE_LIMIT, 8: consecutive video grants tolerated while the host is pending before the host is forced a slot (1..15).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- vid_req  in  1  video lookup request; held with address until vid_gnt.
- vid_char  in  8  video character code.
- vid_row  in  3  video glyph row.
- vid_inv  in  1  invert returned byte (reverse video).
- vid_gnt  out  1  combinational grant; request consumed this cycle.
- vid_rvalid  out  1  one-cycle pulse; vid_rdata valid.
- vid_rdata  out  8  glyph row byte, MSB = leftmost pixel.
- vid_miss  out  1  registered pulse: vid_req was high last cycle and was not granted.
- host_valid  in  1  host lookup request; held stable until host_ready.
- host_char  in  8  host character code.
- host_row  in  3  host glyph row.
- host_ready  out  1  combinational grant to the host.
- host_rvalid  out  1  one-cycle pulse; host_rdata valid.
- host_rdata  out  8  raw glyph row byte (never inverted).
- rom_ad  out  11  ROM address {char, row}.
- rom_ce  out  1  ROM clock enable, high only on issue cycles.
- rom_oce  out  1  ROM output-register enable, constant 1 after reset.
- rom_reset  out  1  ROM synchronous reset, driven directly from reset.
- rom_dout  in  8  ROM read data.

## Operation
- Arbitration is combinational each cycle:
  - Neither requester asserted: no issue.
  - Exactly one asserted: that requester is granted.
  - Both asserted: video is granted, unless starve_cnt == STARVE_LIMIT, in which case the host is granted.
- starve_cnt is a 4-bit register:
  - Increments on every cycle where video is granted while host_valid is high.
  - Clears on any host grant, and on any cycle where host_valid is low.
  - Never exceeds STARVE_LIMIT.
- Issue cycle T:
  - rom_ce = 1; rom_ad = granted {char, row}.
  - Tag stage 0 is loaded with {valid=1, src (0 = video, 1 = host), inv = vid_inv & ~src}.
  - On non-issue cycles rom_ce = 0, rom_ad holds its last value, and tag stage 0 is loaded with valid=0.
- Tag pipeline is two stages deep (stage0 → stage1), aligned so that stage1 describes rom_dout in cycle T+2.
- Return register, updated in cycle T+2:
  - If stage1.valid and src = video: vid_rdata <= rom_dout ^ {8{inv}} and vid_rvalid <= 1.
  - If stage1.valid and src = host: host_rdata <= rom_dout and host_rvalid <= 1.
  - Data outputs hold their value between pulses.
- Responses return strictly in issue order. Throughput is one lookup per cycle, sustained. Requesters have no backpressure and must accept the response pulse.
- vid_miss is registered: vid_miss(t+1) = vid_req(t) & ~vid_gnt(t).

## Timing
- Grant to response: request granted in cycle T; rvalid and rdata are visible in cycle T+3, i.e. 3 clock edges after the grant edge.
- Reset (asynchronous assert, synchronous release) sets:
  - vid_rvalid = host_rvalid = vid_miss = 0.
  - vid_rdata = host_rdata = 0x00.
  - rom_ad = 0, rom_ce = 0, rom_oce = 0.
  - starve_cnt = 0; both tag stages invalid.
- First cycle after reset release:
  - rom_oce = 1.
  - Grants are permitted in that same cycle.
- Reset mid-flight: every in-flight lookup is dropped, and no rvalid is generated for it after release.
- Simultaneous requests at the starvation limit: the host is granted, vid_gnt = 0, vid_miss pulses in the next cycle, and starve_cnt clears to 0.
- Back-to-back grants to alternating sources must each return to the correct port, with no merged or lost pulses.
- Row and char wrap: no address arithmetic is performed; {char, row} maps straight onto rom_ad. Both 0x7FF and 0x000 are legal addresses.

## Test plan
- Single video lookup: char 0x41, row 1, inv 0, ROM model loaded with the font image → vid_gnt in T, rom_ad = 0x209 in T, vid_rvalid in T+3 with data 0x24, host_rvalid stays 0.
- Inverted video: same lookup with inv = 1 → vid_rdata = 0xDB; then host reads 0x41 row 1 → host_rdata = 0x24 (never inverted).
- Starvation: vid_req and host_valid held high for 20 cycles, STARVE_LIMIT = 8 → exactly 2 host grants, at the 9th and 18th cycle; vid_miss pulses on the cycle after each; 18 video grants in total.
- Streaming: video requests rows 0..7 of char 0x00 on consecutive cycles → 8 consecutive vid_rvalid pulses with data in order 0x00, 0x00, 0x00, 0x00, 0x00, 0x00, 0x00, 0x00 matching the model; no gaps.
- Alternating sources every cycle, 16 cycles → response order and port routing match issue order exactly, checked against a scoreboard.
- Reset asserted for one cycle, 1 cycle after a grant → no rvalid on either port afterwards, all outputs at reset values, starve_cnt = 0, and the next lookup after release completes normally in 3 cycles.

Source files
------------

// File: rtl/font_rom_arbiter.sv
// Arbitrates the shared character-generator ROM between video scanout and host readback.
// Tracks each issued lookup through a tag pipeline so its data returns to the port that asked.
module font_rom_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vid_req,
   input  logic [7:0]  vid_char,
   input  logic [2:0]  vid_row,
   input  logic        vid_inv,
   output logic        vid_gnt,
   output logic        vid_rvalid,
   output logic [7:0]  vid_rdata,
   output logic        vid_miss,
   input  logic        host_valid,
   input  logic [7:0]  host_char,
   input  logic [2:0]  host_row,
   output logic        host_ready,
   output logic        host_rvalid,
   output logic [7:0]  host_rdata,
   output logic [10:0] rom_ad,
   output logic        rom_ce,
   output logic        rom_oce,
   output logic        rom_reset,
   input  logic [7:0]  rom_dout
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  starve_q, starve_d;
   logic [10:0] ad_q, ad_d;
   logic        oce_q, oce_d;
   logic        t0_v_q, t0_v_d, t0_src_q, t0_src_d, t0_inv_q, t0_inv_d;
   logic        t1_v_q, t1_v_d, t1_src_q, t1_src_d, t1_inv_q, t1_inv_d;
   logic        vrv_q, vrv_d, hrv_q, hrv_d, miss_q, miss_d;
   logic [7:0]  vdat_q, vdat_d, hdat_q, hdat_d;
   logic        issue;

   always_comb begin
      vid_gnt    = 1'b0;
      host_ready = 1'b0;
      if (!reset) begin
         if (vid_req && host_valid) begin
            if (starve_q == LIMIT) host_ready = 1'b1;
            else                   vid_gnt    = 1'b1;
         end else if (vid_req) begin
            vid_gnt = 1'b1;
         end else if (host_valid) begin
            host_ready = 1'b1;
         end
      end
      issue = vid_gnt | host_ready;

      starve_d = starve_q;
      if (host_ready || !host_valid)
         starve_d = '0;
      else if (vid_gnt && starve_q != LIMIT)
         starve_d = starve_q + 4'd1;

      // Address register only moves on issue so the ROM sees a stable bus
      ad_d = ad_q;
      if (host_ready)   ad_d = {host_char, host_row};
      else if (vid_gnt) ad_d = {vid_char, vid_row};
      oce_d = 1'b1;

      t0_v_d   = issue;
      t0_src_d = host_ready;
      t0_inv_d = vid_gnt & vid_inv;
      t1_v_d   = t0_v_q;
      t1_src_d = t0_src_q;
      t1_inv_d = t0_inv_q;

      vrv_d  = t1_v_q & ~t1_src_q;
      hrv_d  = t1_v_q & t1_src_q;
      vdat_d = vdat_q;
      hdat_d = hdat_q;
      if (vrv_d) vdat_d = rom_dout ^ {8{t1_inv_q}};
      if (hrv_d) hdat_d = rom_dout;
      miss_d = vid_req & ~vid_gnt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
         ad_q     <= '0;
         oce_q    <= 1'b0;
         t0_v_q   <= 1'b0;
         t0_src_q <= 1'b0;
         t0_inv_q <= 1'b0;
         t1_v_q   <= 1'b0;
         t1_src_q <= 1'b0;
         t1_inv_q <= 1'b0;
         vrv_q    <= 1'b0;
         hrv_q    <= 1'b0;
         miss_q   <= 1'b0;
         vdat_q   <= '0;
         hdat_q   <= '0;
      end else begin
         starve_q <= starve_d;
         ad_q     <= ad_d;
         oce_q    <= oce_d;
         t0_v_q   <= t0_v_d;
         t0_src_q <= t0_src_d;
         t0_inv_q <= t0_inv_d;
         t1_v_q   <= t1_v_d;
         t1_src_q <= t1_src_d;
         t1_inv_q <= t1_inv_d;
         vrv_q    <= vrv_d;
         hrv_q    <= hrv_d;
         miss_q   <= miss_d;
         vdat_q   <= vdat_d;
         hdat_q   <= hdat_d;
      end
   end

   assign rom_ad      = ad_d;
   assign rom_ce      = issue;
   assign rom_oce     = oce_q;
   assign rom_reset   = reset;
   assign vid_rvalid  = vrv_q;
   assign vid_rdata   = vdat_q;
   assign vid_miss    = miss_q;
   assign host_rvalid = hrv_q;
   assign host_rdata  = hdat_q;

endmodule
